// File: rtl/ahb_pkg.sv
// Shared AHB types and defaults for the request-to-AHB master.
package ahb_pkg;

  // Byte address and data word carried on the AHB side.
  typedef logic [31:0] AHB_ADDR4_T;
  typedef logic [31:0] AHB_DATA4_T;

  // Default data-phase cycle limit before a transfer is abandoned.
  localparam int AHB_TIMEOUT_DFLT = 16;

  // Default parking address; must decode to no slave.
  localparam AHB_ADDR4_T AHB_PARK_ADDR_DFLT = 32'hFFFF_FFFF;

  // Width of the data-phase wait counter (saturates at all-ones).
  localparam int AHB_TMO_CNT_W = 5;

  // Transfer sequencing: idle, single address cycle, data phase.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } ahb_mst_state_e;

endpackage : ahb_pkg

// File: rtl/ahb_req_master.sv
// Single-outstanding AHB master: turns a valid/ready request into one
// non-pipelined AHB transfer and returns a one-cycle response pulse.
// A data phase stalled for TIMEOUT cycles is abandoned with rsp_err set.
// TIMEOUT is expected to lie in 1..32 so the 5-bit counter can reach it.
module ahb_req_master
  import ahb_pkg::*;
#(
  parameter AHB_ADDR4_T PARK_ADDR = AHB_PARK_ADDR_DFLT,
  parameter int         TIMEOUT   = AHB_TIMEOUT_DFLT
) (
  input  logic       hclk,
  input  logic       hresetn,
  // request side
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  AHB_ADDR4_T req_addr,
  input  AHB_DATA4_T req_wdata,
  // response side
  output logic       rsp_valid,
  output AHB_DATA4_T rsp_rdata,
  output logic       rsp_err,
  // AHB side
  output AHB_ADDR4_T haddr,
  output logic       hwrite,
  output AHB_DATA4_T hwdata,
  input  logic       hready,
  input  AHB_DATA4_T hrdata
);

  localparam logic [AHB_TMO_CNT_W-1:0] TMO_LAST = AHB_TMO_CNT_W'(TIMEOUT - 1);

  // Saturating increment for the data-phase wait counter.
  function automatic logic [AHB_TMO_CNT_W-1:0] sat_inc(
    input logic [AHB_TMO_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  ahb_mst_state_e             state_q,     state_d;
  logic [AHB_TMO_CNT_W-1:0]   cnt_q,       cnt_d;
  logic                       req_ready_q, req_ready_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_err_q,   rsp_err_d;
  AHB_DATA4_T                 rsp_rdata_q, rsp_rdata_d;
  AHB_ADDR4_T                 addr_q,      addr_d;
  logic                       write_q,     write_d;
  AHB_DATA4_T                 wdata_q,     wdata_d;

  // Next-state, request capture, timeout counting and response generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;

    unique case (state_q)
      IDLE: begin
        // req_ready_q gates acceptance so nothing is taken in the
        // first cycle after reset release.
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          write_d = req_write;
          wdata_d = req_wdata;
          state_d = ADDR;
        end
      end
      ADDR: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        // A ready slave always wins over an expiring counter.
        if (hready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? '0 : hrdata;
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // Control and response registers; reset abandons any transfer in flight.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Latched request fields; only observed outside IDLE, so no reset needed.
  always_ff @(posedge hclk) begin
    addr_q  <= addr_d;
    write_q <= write_d;
    wdata_q <= wdata_d;
  end

  // AHB bus drive: address only during ADDR, write data only during DATA.
  always_comb begin
    haddr  = PARK_ADDR;
    hwrite = 1'b0;
    hwdata = '0;
    unique case (state_q)
      ADDR: begin
        haddr  = addr_q;
        hwrite = write_q;
      end
      DATA: begin
        hwdata = write_q ? wdata_q : '0;
      end
      default: begin
        haddr  = PARK_ADDR;
      end
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule : ahb_req_master

// File: doc/ahb_req_master.md
AHB_REQ_MASTER -- requirements
Module: ahb_req_master

Interface
REQ-001 Parameter PARK_ADDR, default 32'hFFFF_FFFF: haddr driven whenever no address phase is active; SHALL lie outside every slave range.
REQ-002 Parameter TIMEOUT, default 16: maximum data-phase cycles before the transfer is abandoned.
REQ-003 Port hclk  input  1: single clock, all state updates on its rising edge.
REQ-004 Port hresetn  input  1: reset, asynchronous assert, active-low.
REQ-005 Port req_valid  input  1: request offered.
REQ-006 Port req_ready  output  1: request accepted when high together with req_valid at a rising hclk edge.
REQ-007 Port req_write  input  1: 1 = write, 0 = read.
REQ-008 Port req_addr  input  32: byte address (AHB_ADDR4_T).
REQ-009 Port req_wdata  input  32: write data (AHB_DATA4_T).
REQ-010 Port rsp_valid  output  1: one-cycle pulse, transfer finished.
REQ-011 Port rsp_rdata  output  32: read data, valid with rsp_valid on reads, 0 otherwise.
REQ-012 Port rsp_err  output  1: timeout flag, valid with rsp_valid.
REQ-013 Port haddr  output  32: AHB address.
REQ-014 Port hwrite  output  1: AHB direction.
REQ-015 Port hwdata  output  32: AHB write data.
REQ-016 Port hready  input  1: AHB ready from slaves/interconnect, idle-pulled high.
REQ-017 Port hrdata  input  32: AHB read data.

Function
REQ-018 FSM states SHALL be IDLE, ADDR, DATA; encoding in an enum typedef.
REQ-019 IDLE: req_ready = 1; req_valid at rising edge -> latch addr/write/wdata, go ADDR.
REQ-020 ADDR (exactly one cycle): haddr = latched addr, hwrite = latched write; next edge -> DATA, timeout counter cleared.
REQ-021 DATA: haddr = PARK_ADDR, hwrite = 0; hwdata = latched wdata on writes, 0 on reads.
REQ-022 DATA completes at first rising edge with hready = 1: reads capture hrdata into rsp_rdata; rsp_valid = 1 for the following cycle; return to IDLE.
REQ-023 No address pipelining: the next ADDR phase SHALL start no earlier than the cycle after DATA completes; min 3 cycles per transfer.
REQ-024 req_ready SHALL be 0 in ADDR and DATA; requests held by the source.
REQ-025 Timeout counter: 5-bit saturating, increments each DATA cycle with hready = 0; reaching TIMEOUT-1 -> rsp_valid with rsp_err = 1, rsp_rdata = 0, return to IDLE.
REQ-026 hready = 1 on the same edge the counter reaches TIMEOUT-1 -> normal completion wins, rsp_err = 0.
REQ-027 In IDLE haddr = PARK_ADDR, hwrite = 0, hwdata = 0.
REQ-028 hready value during IDLE and ADDR SHALL be ignored.

Reset
REQ-029 hresetn low SHALL immediately force IDLE, req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, haddr = PARK_ADDR, hwrite = 0, hwdata = 0, counter = 0.
REQ-030 Reset mid-transfer SHALL abandon the transfer with no response; req_ready rises on the first edge after hresetn deasserts.

Structure
REQ-031 FSM state typedef and TIMEOUT default belong in ahb_pkg next to AHB_ADDR4_T/AHB_DATA4_T.
REQ-032 Single module, no sub-modules; connects to a slave through ahb_ifc in the top level.

Verification
REQ-033 Write 0x10 data 0xDEADBEEF, hready held 1 -> haddr 0x10 for 1 cycle, hwdata 0xDEADBEEF next cycle, rsp_valid 1 cycle later, rsp_err 0.
REQ-034 Read back 0x10 from a memory slave at ADDR_LO 0 -> rsp_rdata 0xDEADBEEF, rsp_err 0.
REQ-035 req_valid held high for 4 writes (0x0..0x3) -> each ADDR phase separated by 3 cycles, PARK_ADDR in every DATA phase.
REQ-036 Read 0x20 with hready held 0 -> rsp_valid with rsp_err 1 and rsp_rdata 0 after 16 DATA cycles.
REQ-037 hready rises exactly on the 16th DATA cycle -> rsp_err 0, data captured.
REQ-038 hresetn pulsed low during DATA of a write -> outputs at reset values at once, no rsp_valid, next request serviced normally.
